// File: rtl/cv32e40x_pkg.sv
// Shared types for the sequential divider: operator encoding, FSM states
// and the iteration-counter width.
package cv32e40x_pkg;

  localparam int DIV_ITER_CNT_W = 5;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'd0,
    DIV_DIVU = 2'd1,
    DIV_REM  = 2'd2,
    DIV_REMU = 2'd3
  } div_opcode_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ITER = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/cv32e40x_div_clz.sv
// 32-bit leading-zero counter, purely combinational.
// Returns 32 (6'b100000) for an all-zero input.
module cv32e40x_div_clz (
  input  logic [31:0] data,
  output logic [5:0]  lz_cnt
);

  // Scan upward so the highest set bit is the last one to write the count
  always_comb begin
    lz_cnt = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (data[i]) begin
        lz_cnt = 6'(31 - i);
      end
    end
  end

endmodule

// File: rtl/cv32e40x_div_seq.sv
// Sequential radix-2 restore-compare divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle on magnitudes, sign correction on the output.
// Optional build macro CV32E40X_DIV_EARLY_EXIT_EN: skips the leading-zero
// bits of the dividend magnitude to shorten latency (results unchanged).
module cv32e40x_div_seq
  import cv32e40x_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  div_opcode_e operator_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic [31:0] result_o,
  output logic        valid_o,
  output logic        ready_o,
  input  logic        ready_i
);

  div_state_e                state_q, state_d;
  logic [31:0]               q_reg, q_nxt;
  logic [31:0]               r_reg, r_nxt;
  logic [31:0]               d_reg, d_nxt;
  logic [DIV_ITER_CNT_W-1:0] cnt_q, cnt_nxt;
  logic                      neg_q, neg_q_nxt;
  logic                      neg_r, neg_r_nxt;

  logic                      is_signed;
  logic                      is_rem;
  logic                      sa, sb;
  logic signed [31:0]        abs_a, abs_b;
  logic                      div_zero;
  logic                      div_ovf;
  logic [32:0]               t;

  // Conditional two's-complement negation used for the final sign fix
  function automatic logic [31:0] sign_fix(input logic [31:0] v, input logic neg);
    sign_fix = neg ? (32'd0 - v) : v;
  endfunction

  // Operand classification and magnitudes
  always_comb begin
    is_signed = (operator_i == DIV_DIV) || (operator_i == DIV_REM);
    is_rem    = (operator_i == DIV_REM) || (operator_i == DIV_REMU);
    sa        = is_signed & op_a_i[31];
    sb        = is_signed & op_b_i[31];
    abs_a     = sa ? (32'd0 - op_a_i) : op_a_i;
    abs_b     = sb ? (32'd0 - op_b_i) : op_b_i;
    div_zero  = (op_b_i == 32'd0);
    div_ovf   = is_signed && (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF);
    // Partial remainder with the next dividend bit shifted in, minus divisor;
    // r_reg < d_reg keeps the true difference inside signed 33-bit range
    t         = {r_reg, q_reg[31]} - {1'b0, d_reg};
  end

`ifdef CV32E40X_DIV_EARLY_EXIT_EN
  logic [5:0] lz_a;

  cv32e40x_div_clz u_clz (
    .data   (abs_a),
    .lz_cnt (lz_a)
  );
`endif

  // Next-state, datapath next values and handshake outputs
  always_comb begin
    state_d   = state_q;
    q_nxt     = q_reg;
    r_nxt     = r_reg;
    d_nxt     = d_reg;
    cnt_nxt   = cnt_q;
    neg_q_nxt = neg_q;
    neg_r_nxt = neg_r;
    valid_o   = 1'b0;
    ready_o   = 1'b0;

    case (state_q)
      DIV_IDLE: begin
        if (valid_i) begin
          if (div_zero) begin
            q_nxt     = 32'hFFFF_FFFF;
            r_nxt     = op_a_i;
            neg_q_nxt = 1'b0;
            neg_r_nxt = 1'b0;
            state_d   = DIV_DONE;
          end else if (div_ovf) begin
            q_nxt     = 32'h8000_0000;
            r_nxt     = 32'd0;
            neg_q_nxt = 1'b0;
            neg_r_nxt = 1'b0;
            state_d   = DIV_DONE;
          end else begin
            d_nxt     = abs_b;
            r_nxt     = 32'd0;
            neg_q_nxt = sa ^ sb;
            neg_r_nxt = sa;
            state_d   = DIV_ITER;
`ifdef CV32E40X_DIV_EARLY_EXIT_EN
            if (lz_a[5]) begin
              // Zero dividend: quotient and remainder are both zero
              q_nxt     = 32'd0;
              neg_q_nxt = 1'b0;
              neg_r_nxt = 1'b0;
              state_d   = DIV_DONE;
            end else begin
              q_nxt   = abs_a << lz_a[4:0];
              cnt_nxt = 5'd31 - lz_a[4:0];
            end
`else
            q_nxt   = abs_a;
            cnt_nxt = 5'd31;
`endif
          end
        end
      end
      DIV_ITER: begin
        if (!t[32]) begin
          r_nxt = t[31:0];
          q_nxt = {q_reg[30:0], 1'b1};
        end else begin
          r_nxt = {r_reg[30:0], q_reg[31]};
          q_nxt = {q_reg[30:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = DIV_DONE;
        end else begin
          cnt_nxt = cnt_q - 1'b1;
        end
      end
      DIV_DONE: begin
        valid_o = 1'b1;
        if (ready_i) begin
          ready_o = 1'b1;
          state_d = DIV_IDLE;
        end
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    // Kill: dropping valid_i abandons any operation, including a pending result
    if (!valid_i) begin
      state_d   = DIV_IDLE;
      q_nxt     = q_reg;
      r_nxt     = r_reg;
      d_nxt     = d_reg;
      cnt_nxt   = cnt_q;
      neg_q_nxt = neg_q;
      neg_r_nxt = neg_r;
      valid_o   = 1'b0;
      ready_o   = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
      r_reg <= '0;
      d_reg <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      q_reg <= q_nxt;
      r_reg <= r_nxt;
      d_reg <= d_nxt;
      cnt_q <= cnt_nxt;
      neg_q <= neg_q_nxt;
      neg_r <= neg_r_nxt;
    end
  end

  // Result selection with sign correction, forced to zero when not valid
  always_comb begin
    result_o = 32'd0;
    if (valid_o) begin
      result_o = is_rem ? sign_fix(r_reg, neg_r) : sign_fix(q_reg, neg_q);
    end
  end

endmodule

// File: tb/tb_cv32e40x_div_seq.sv
// Directed and randomized checks of cv32e40x_div_seq with a result scoreboard.
module tb_cv32e40x_div_seq;
  import cv32e40x_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  div_opcode_e operator_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [31:0] result_o;
  logic        valid_o;
  logic        ready_o;
  logic        ready_i;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];

  cv32e40x_div_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .operator_i (operator_i),
    .op_a_i     (op_a_i),
    .op_b_i     (op_b_i),
    .result_o   (result_o),
    .valid_o    (valid_o),
    .ready_o    (ready_o),
    .ready_i    (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RV32M reference semantics
  function automatic logic [31:0] ref_div(input div_opcode_e op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sbv;
    logic               is_rem;
    logic               is_sgn;
    sa     = a;
    sbv    = b;
    is_rem = (op == DIV_REM) || (op == DIV_REMU);
    is_sgn = (op == DIV_DIV) || (op == DIV_REM);
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (is_sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return is_rem ? 32'd0 : 32'h8000_0000;
    if (is_sgn) return is_rem ? 32'(sa % sbv) : 32'(sa / sbv);
    return is_rem ? (a % b) : (a / b);
  endfunction

  // Cycle on which valid_o is expected, counting the request cycle as 0
  function automatic int exp_lat(input div_opcode_e op, input logic [31:0] a,
                                 input logic [31:0] b);
    logic        is_sgn;
    logic [31:0] mag;
    int          n;
    is_sgn = (op == DIV_DIV) || (op == DIV_REM);
    if (b == 32'd0) return 1;
    if (is_sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    mag = (is_sgn && a[31]) ? (32'd0 - a) : a;
    n   = 0;
`ifdef CV32E40X_DIV_EARLY_EXIT_EN
    if (mag == 32'd0) return 1;
    for (int i = 31; i >= 0; i--) begin
      if (mag[i]) break;
      n++;
    end
`else
    if (mag == 32'hFFFF_FFFF) n = 0;
`endif
    return 33 - n;
  endfunction

  // Present one request, wait for the result, check latency/value, hand it off.
  // Called at 1 time unit after a rising edge; returns at the same phase.
  task automatic run_op(input string tag, input div_opcode_e op, input logic [31:0] a,
                        input logic [31:0] b);
    int          lat;
    logic [31:0] exp;
    operator_i = op;
    op_a_i     = a;
    op_b_i     = b;
    valid_i    = 1'b1;
    ready_i    = 1'b1;
    sb_q.push_back(ref_div(op, a, b));
    lat = 0;
    #1;
    while (!valid_o && lat < 200) begin
      @(posedge clk);
      #2;
      lat++;
    end
    if (!valid_o) begin
      check({tag, "_timeout"}, 32'(valid_o), 32'd1);
      void'(sb_q.pop_front());
    end else begin
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat(op, a, b)));
      exp = sb_q.pop_front();
      check({tag, "_res"}, result_o, exp);
      check({tag, "_rdy"}, 32'(ready_o), 32'd1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp;
    logic [31:0] held;
    int          lat;
    div_opcode_e rop;
    logic [31:0] ra, rb;

    rst_n      = 1'b0;
    valid_i    = 1'b0;
    ready_i    = 1'b0;
    operator_i = DIV_DIV;
    op_a_i     = 32'd0;
    op_b_i     = 32'd0;
    #2;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_state", 32'(dut.state_q), 32'(DIV_IDLE));
    check("idle_ready", 32'(ready_o), 32'd1);

    run_op("div_100_7", DIV_DIV, 32'd100, 32'd7);
    run_op("rem_100_7", DIV_REM, 32'd100, 32'd7);
    run_op("div_m7_2", DIV_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2", DIV_REM, 32'hFFFF_FFF9, 32'd2);
    run_op("remu_f9_2", DIV_REMU, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_by0", DIV_DIVU, 32'd1234, 32'd0);
    run_op("rem_by0", DIV_REM, 32'd1234, 32'd0);
    run_op("div_ovf", DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_7_m2", DIV_DIV, 32'd7, 32'hFFFF_FFFE);
    run_op("divu_max", DIV_DIVU, 32'hFFFF_FFFF, 32'd1);
    valid_i = 1'b0;
    @(posedge clk);
    #1;

    // Kill in the middle of an iteration
    operator_i = DIV_DIV;
    op_a_i     = 32'd100000;
    op_b_i     = 32'd3;
    valid_i    = 1'b1;
    ready_i    = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("iter_valid", 32'(valid_o), 32'd0);
    check("iter_ready", 32'(ready_o), 32'd0);
    check("iter_result", result_o, 32'd0);
    valid_i = 1'b0;
    #1;
    check("kill_ready", 32'(ready_o), 32'd1);
    check("kill_valid", 32'(valid_o), 32'd0);
    @(posedge clk);
    #1;
    check("kill_state", 32'(dut.state_q), 32'(DIV_IDLE));
    run_op("divu_50_5", DIV_DIVU, 32'd50, 32'd5);
    valid_i = 1'b0;
    @(posedge clk);
    #1;

    // Backpressure in DIV_DONE
    operator_i = DIV_DIVU;
    op_a_i     = 32'd1000;
    op_b_i     = 32'd3;
    valid_i    = 1'b1;
    ready_i    = 1'b0;
    sb_q.push_back(ref_div(DIV_DIVU, 32'd1000, 32'd3));
    lat = 0;
    #1;
    while (!valid_o && lat < 200) begin
      @(posedge clk);
      #2;
      lat++;
    end
    check("bp_lat", 32'(lat), 32'(exp_lat(DIV_DIVU, 32'd1000, 32'd3)));
    exp  = sb_q.pop_front();
    held = result_o;
    check("bp_res", held, exp);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_hold", 32'(valid_o), 32'd1);
      check("bp_res_hold", result_o, exp);
      check("bp_ready_low", 32'(ready_o), 32'd0);
      @(posedge clk);
      #2;
    end
    ready_i = 1'b1;
    #1;
    check("bp_ready_high", 32'(ready_o), 32'd1);
    check("bp_res_final", result_o, exp);
    @(posedge clk);
    #1;
    check("bp_back_idle", 32'(dut.state_q), 32'(DIV_IDLE));

`ifdef CV32E40X_DIV_EARLY_EXIT_EN
    run_op("ee_divu_5_3", DIV_DIVU, 32'd5, 32'd3);
    run_op("ee_divu_0_3", DIV_DIVU, 32'd0, 32'd3);
    run_op("ee_rem_0_m3", DIV_REM, 32'd0, 32'hFFFF_FFFD);
`endif

    // Back-to-back randomized operations against the reference model
    for (int k = 0; k < 12; k++) begin
      rop = div_opcode_e'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (k % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (k % 4 == 1) rb = 32'd0 - rb;
      if (k % 5 == 2) ra = ra >> $urandom_range(0, 31);
      run_op("rand", rop, ra, rb);
    end
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
